// File: rtl/pi1_pkg.sv
// Shared definitions for the PI1 bus: op encodings, SRAM FSM states, clog2 helper.
package pi1_pkg;

  localparam logic [1:0] PINOOP = 2'b00;
  localparam logic [1:0] PIWROP = 2'b01;
  localparam logic [1:0] PIRDOP = 2'b10;
  localparam logic [1:0] PIRWOP = 2'b11;

  typedef enum logic {IDLE, WAIT} pi1_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if (v > (1 << i)) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/pi1_sram_if.sv
// PI1 bus bundle between a master and the pi1_sram slave; names are from the slave's view.
interface pi1_sram_if #(
  parameter int ARCHBITSZ = 32
);
  import pi1_pkg::*;

  localparam int ADDRW = ARCHBITSZ - clog2(ARCHBITSZ / 8);

  logic [1:0]             pi1_op_i;
  logic [ADDRW-1:0]       pi1_addr_i;
  logic [ARCHBITSZ-1:0]   pi1_data_i;
  logic [ARCHBITSZ-1:0]   pi1_data_o;
  logic [ARCHBITSZ/8-1:0] pi1_sel_i;
  logic                   pi1_rdy_o;
  logic [ADDRW-1:0]       pi1_mapsz_o;

  modport master (
    output pi1_op_i, pi1_addr_i, pi1_data_i, pi1_sel_i,
    input  pi1_data_o, pi1_rdy_o, pi1_mapsz_o
  );

  modport slave (
    input  pi1_op_i, pi1_addr_i, pi1_data_i, pi1_sel_i,
    output pi1_data_o, pi1_rdy_o, pi1_mapsz_o
  );

endinterface

// File: rtl/pi1_sram_ram.sv
// Single-port, byte-enable, read-first RAM array.
module pi1_sram_ram #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int AW      = 10,
  parameter     SRCFILE = ""
) (
  input  logic                clk_i,
  input  logic                re_i,
  input  logic [DATA_W/8-1:0] we_i,
  input  logic [AW-1:0]       addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read-first: the read samples the word before this edge's lane writes land.
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[addr_i];
    for (int b = 0; b < DATA_W / 8; b++)
      if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pi1_sram.sv
// PI1 SRAM slave: handshake FSM, wait counter and output hold around pi1_sram_ram.
// Define PI1_SRAM_RWOP_EN to make op 11 an atomic read-write swap; otherwise it is a plain read.
module pi1_sram
  import pi1_pkg::*;
#(
  parameter int ARCHBITSZ = 32,
  parameter int SIZE      = 1024,
  parameter int DELAY     = 0,
  parameter     SRCFILE   = ""
) (
  input  logic      clk_i,
  input  logic      rst_i,
  pi1_sram_if.slave pi1
);

  localparam int ADDRW = ARCHBITSZ - clog2(ARCHBITSZ / 8);
  localparam int IDXW  = clog2(SIZE);
  localparam int SELW  = ARCHBITSZ / 8;

  pi1_state_e           state_q;
  logic [3:0]           cnt_q;
  logic                 rdy_q;
  logic                 rd_pend_q;
  logic                 out_sel_q;
  logic [ARCHBITSZ-1:0] data_q;
  logic [ARCHBITSZ-1:0] ram_rdata;
  logic [ARCHBITSZ-1:0] data_out;

  logic                 accept;
  logic                 is_rd;
  logic                 is_wr;
  logic [SELW-1:0]      we;
  logic                 unused_addr;

  assign accept = rst_i && (pi1.pi1_op_i != PINOOP) && rdy_q;

`ifdef PI1_SRAM_RWOP_EN
  assign is_rd = (pi1.pi1_op_i == PIRDOP) || (pi1.pi1_op_i == PIRWOP);
  assign is_wr = (pi1.pi1_op_i == PIWROP) || (pi1.pi1_op_i == PIRWOP);
`else
  assign is_rd = (pi1.pi1_op_i == PIRDOP) || (pi1.pi1_op_i == PIRWOP);
  assign is_wr = (pi1.pi1_op_i == PIWROP);
`endif

  assign we = (accept && is_wr) ? pi1.pi1_sel_i : '0;

  // Upper address bits beyond the array depth wrap silently.
  assign unused_addr = ^pi1.pi1_addr_i[ADDRW-1:IDXW];

  pi1_sram_ram #(
    .DATA_W  (ARCHBITSZ),
    .DEPTH   (SIZE),
    .AW      (IDXW),
    .SRCFILE (SRCFILE)
  ) u_ram (
    .clk_i   (clk_i),
    .re_i    (accept && is_rd),
    .we_i    (we),
    .addr_i  (pi1.pi1_addr_i[IDXW-1:0]),
    .wdata_i (pi1.pi1_data_i),
    .rdata_o (ram_rdata)
  );

  // The RAM's read register updates at acceptance; data_q holds the previous result
  // until the response is due, and out_sel_q switches the output over at that point.
  assign data_out = out_sel_q ? ram_rdata : data_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rdy_q     <= 1'b1;
      rd_pend_q <= 1'b0;
      out_sel_q <= 1'b0;
      data_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_rd) begin
              data_q    <= data_out;
              out_sel_q <= (DELAY == 0);
            end
            if (DELAY != 0) begin
              state_q   <= WAIT;
              cnt_q     <= 4'(DELAY);
              rdy_q     <= 1'b0;
              rd_pend_q <= is_rd;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rdy_q     <= 1'b1;
            rd_pend_q <= 1'b0;
            if (rd_pend_q) out_sel_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pi1.pi1_data_o  = data_out;
  assign pi1.pi1_rdy_o   = rdy_q;
  assign pi1.pi1_mapsz_o = ADDRW'(SIZE);

endmodule

// File: tb/tb_pi1_sram.sv
// Directed bench for pi1_sram: three instances with DELAY 0, 3 and 5 sharing clock and reset.
module tb_pi1_sram;

  localparam logic [1:0] OP_NO = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] OP_RW = 2'b11;

`ifdef PI1_SRAM_RWOP_EN
  localparam logic [31:0] SWAP_EXP = 32'hCAFEF00D;
`else
  localparam logic [31:0] SWAP_EXP = 32'h0000_0000;
`endif

  logic clk;
  logic rst;

  logic [1:0]  op_v   [3];
  logic [29:0] addr_v [3];
  logic [31:0] wd_v   [3];
  logic [3:0]  sel_v  [3];
  logic [31:0] rd_w   [3];
  logic        rdy_w  [3];
  logic [29:0] msz_w  [3];

  int checks = 0;
  int errors = 0;
  int d0_rdy_low = 0;
  logic d0_phase = 1'b0;

  pi1_sram_if #(.ARCHBITSZ(32)) if0 ();
  pi1_sram_if #(.ARCHBITSZ(32)) if3 ();
  pi1_sram_if #(.ARCHBITSZ(32)) if5 ();

  assign if0.pi1_op_i = op_v[0];
  assign if0.pi1_addr_i = addr_v[0];
  assign if0.pi1_data_i = wd_v[0];
  assign if0.pi1_sel_i = sel_v[0];
  assign rd_w[0] = if0.pi1_data_o;
  assign rdy_w[0] = if0.pi1_rdy_o;
  assign msz_w[0] = if0.pi1_mapsz_o;

  assign if3.pi1_op_i = op_v[1];
  assign if3.pi1_addr_i = addr_v[1];
  assign if3.pi1_data_i = wd_v[1];
  assign if3.pi1_sel_i = sel_v[1];
  assign rd_w[1] = if3.pi1_data_o;
  assign rdy_w[1] = if3.pi1_rdy_o;
  assign msz_w[1] = if3.pi1_mapsz_o;

  assign if5.pi1_op_i = op_v[2];
  assign if5.pi1_addr_i = addr_v[2];
  assign if5.pi1_data_i = wd_v[2];
  assign if5.pi1_sel_i = sel_v[2];
  assign rd_w[2] = if5.pi1_data_o;
  assign rdy_w[2] = if5.pi1_rdy_o;
  assign msz_w[2] = if5.pi1_mapsz_o;

  pi1_sram #(.ARCHBITSZ(32), .SIZE(1024), .DELAY(0)) u_d0 (.clk_i(clk), .rst_i(rst), .pi1(if0));
  pi1_sram #(.ARCHBITSZ(32), .SIZE(1024), .DELAY(3)) u_d3 (.clk_i(clk), .rst_i(rst), .pi1(if3));
  pi1_sram #(.ARCHBITSZ(32), .SIZE(1024), .DELAY(5)) u_d5 (.clk_i(clk), .rst_i(rst), .pi1(if5));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (d0_phase && rdy_w[0] !== 1'b1) d0_rdy_low++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request at a falling edge, let the next rising edge take it, then go idle.
  task automatic issue(input int d, input logic [1:0] op, input logic [29:0] a,
                       input logic [31:0] wd, input logic [3:0] s);
    op_v[d] = op;
    addr_v[d] = a;
    wd_v[d] = wd;
    sel_v[d] = s;
    @(posedge clk);
    @(negedge clk);
    op_v[d] = OP_NO;
  endtask

  task automatic wait_rdy(input int d, output int n);
    n = 0;
    while (rdy_w[d] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  int n;

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      op_v[d] = OP_NO;
      addr_v[d] = '0;
      wd_v[d] = '0;
      sel_v[d] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_rdy", 32'(rdy_w[d]), 32'd1);
      chk("rst_data", rd_w[d], 32'h0);
      chk("rst_mapsz", 32'(msz_w[d]), 32'd1024);
    end
    rst = 1'b1;
    @(negedge clk);

    // DELAY=0 instance
    d0_phase = 1'b1;
    issue(0, OP_WR, 30'd5, 32'hDEADBEEF, 4'hF);
    chk("d0_wr_keep", rd_w[0], 32'h0);
    issue(0, OP_RD, 30'd5, 32'h0, 4'h0);
    chk("d0_rd", rd_w[0], 32'hDEADBEEF);
    issue(0, OP_WR, 30'd5, 32'h11223344, 4'b0101);
    issue(0, OP_RD, 30'd5, 32'h0, 4'hF);
    chk("d0_lanes", rd_w[0], 32'hDE22BE44);
    issue(0, OP_WR, 30'd1031, 32'hA5A5A5A5, 4'hF);
    issue(0, OP_RD, 30'd7, 32'h0, 4'hF);
    chk("d0_wrap", rd_w[0], 32'hA5A5A5A5);
    issue(0, OP_WR, 30'd7, 32'hFFFFFFFF, 4'h0);
    issue(0, OP_RD, 30'd7, 32'h0, 4'hF);
    chk("d0_sel0", rd_w[0], 32'hA5A5A5A5);
    issue(0, OP_WR, 30'd9, 32'h0, 4'hF);
    issue(0, OP_RW, 30'd9, 32'hCAFEF00D, 4'hF);
    chk("d0_swap_old", rd_w[0], 32'h0);
    issue(0, OP_RD, 30'd9, 32'h0, 4'hF);
    chk("d0_swap_mem", rd_w[0], SWAP_EXP);
    issue(0, OP_WR, 30'd3, 32'h77777777, 4'hF);
    chk("d0_hold", rd_w[0], SWAP_EXP);
    d0_phase = 1'b0;
    chk("d0_rdy_never_low", 32'(d0_rdy_low), 32'd0);

    // DELAY=3 instance
    issue(1, OP_WR, 30'd5, 32'hDEADBEEF, 4'hF);
    wait_rdy(1, n);
    chk("d3_wr_wait", 32'(n), 32'd3);
    chk("d3_wr_keep", rd_w[1], 32'h0);
    issue(1, OP_RD, 30'd5, 32'h0, 4'hF);
    chk("d3_wait_rdy", 32'(rdy_w[1]), 32'd0);
    chk("d3_wait_hold", rd_w[1], 32'h0);
    op_v[1] = OP_WR;
    addr_v[1] = 30'd5;
    wd_v[1] = 32'h0;
    sel_v[1] = 4'hF;
    @(negedge clk);
    op_v[1] = OP_NO;
    wait_rdy(1, n);
    chk("d3_rd_wait", 32'(n + 1), 32'd3);
    chk("d3_rd", rd_w[1], 32'hDEADBEEF);
    issue(1, OP_RD, 30'd5, 32'h0, 4'hF);
    wait_rdy(1, n);
    chk("d3_ignored", rd_w[1], 32'hDEADBEEF);

    // DELAY=5 instance: reset two cycles into a write
    issue(2, OP_WR, 30'd2, 32'h12345678, 4'hF);
    chk("d5_busy", 32'(rdy_w[2]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("d5_abort_rdy", 32'(rdy_w[2]), 32'd1);
    chk("d5_abort_data", rd_w[2], 32'h0);
    rst = 1'b1;
    @(negedge clk);
    issue(2, OP_RD, 30'd2, 32'h0, 4'hF);
    wait_rdy(2, n);
    chk("d5_rd_wait", 32'(n), 32'd5);
    chk("d5_kept_write", rd_w[2], 32'h12345678);

    // Request coinciding with reset is dropped
    issue(0, OP_RD, 30'd5, 32'h0, 4'hF);
    chk("d0_pre_rst", rd_w[0], 32'hDE22BE44);
    op_v[0] = OP_WR;
    addr_v[0] = 30'd7;
    wd_v[0] = 32'h0;
    sel_v[0] = 4'hF;
    rst = 1'b0;
    @(negedge clk);
    op_v[0] = OP_NO;
    rst = 1'b1;
    chk("d0_rst_data", rd_w[0], 32'h0);
    issue(0, OP_RD, 30'd7, 32'h0, 4'hF);
    chk("d0_rst_drop", rd_w[0], 32'hA5A5A5A5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pi1_sram.md
PI1_SRAM -- requirements
Module: pi1_sram

Interface
REQ-001 SHALL have parameter ARCHBITSZ, default 32, data width in bits; legal values 32, 64, 128.
REQ-002 SHALL have parameter SIZE, default 1024, depth in ARCHBITSZ-wide words; power of two, >= 2.
REQ-003 SHALL have parameter DELAY, default 0, wait cycles added per access; legal range 0..15.
REQ-004 SHALL have parameter SRCFILE, default "", hex init file; if empty, contents start undefined.
REQ-005 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_i, input, 1, reset; synchronous and active-low.
REQ-007 SHALL have port pi1_op_i, input, 2, op: 00 noop, 01 write, 10 read, 11 read-write swap.
REQ-008 SHALL have port pi1_addr_i, input, ARCHBITSZ-clog2(ARCHBITSZ/8), word address.
REQ-009 SHALL have port pi1_data_i, input, ARCHBITSZ, write data.
REQ-010 SHALL have port pi1_data_o, output, ARCHBITSZ, read data.
REQ-011 SHALL have port pi1_sel_i, input, ARCHBITSZ/8, byte-lane enables.
REQ-012 SHALL have port pi1_rdy_o, output, 1, ready / response-valid.
REQ-013 SHALL have port pi1_mapsz_o, output, ARCHBITSZ-clog2(ARCHBITSZ/8), constant SIZE.

Function
REQ-014 A request SHALL be accepted on an edge where rst_i=1, pi1_op_i!=00 and pi1_rdy_o=1; all inputs are sampled on that edge only.
REQ-015 Word index SHALL be pi1_addr_i modulo SIZE (low clog2(SIZE) bits); addresses past SIZE wrap and raise no error.
REQ-016 Writes SHALL update only the lanes whose pi1_sel_i bit is 1; sel=0 on a write SHALL leave memory unchanged.
REQ-017 Reads SHALL return the full word regardless of pi1_sel_i.
REQ-018 A swap SHALL return the pre-write word and write the sel-masked data atomically; the RAM is single-port, so no other access can interleave.
REQ-019 The FSM SHALL have two states, IDLE and WAIT.
REQ-020 With DELAY=0 the block SHALL stay in IDLE with pi1_rdy_o=1; pi1_data_o is valid on the cycle after acceptance, giving back-to-back throughput of one access per cycle.
REQ-021 With DELAY=N>0, acceptance SHALL move IDLE->WAIT and load a 4-bit counter with N.
REQ-022 While in WAIT, pi1_rdy_o SHALL be 0 and the counter decrements once per cycle.
REQ-023 When the counter reaches 0 the block SHALL return to IDLE; pi1_rdy_o returns to 1 with pi1_data_o valid on that same cycle.
REQ-024 Memory writes SHALL commit on the acceptance edge, regardless of DELAY.
REQ-025 pi1_data_o SHALL hold its last read/swap result until the next read/swap completes.
REQ-026 Write-only ops SHALL leave pi1_data_o unchanged.
REQ-027 A read of an address written by the immediately preceding access SHALL return the new data (no stale read).
REQ-028 Ops presented while pi1_rdy_o=0 SHALL be ignored; the master holds them until rdy.
REQ-029 pi1_mapsz_o SHALL equal SIZE at all times, including during reset.

Reset
REQ-030 On an edge with rst_i=0, the block SHALL enter IDLE, clear the counter and drive pi1_rdy_o=1, pi1_data_o=0.
REQ-031 Memory contents SHALL survive reset.
REQ-032 A request on the same edge as reset SHALL be dropped, with no write.
REQ-033 Reset during WAIT SHALL abort the response: read data is discarded and the already-committed write is kept.

Configuration
REQ-034 Macro PI1_SRAM_RWOP_EN defined: op 11 SHALL behave as the atomic swap above.
REQ-035 Macro absent: op 11 SHALL behave exactly as read (op 10), with no write; the write-lane muxing for swap SHALL not be synthesised.

Structure
REQ-036 Shared package pi1_pkg SHALL hold the op encodings PINOOP/PIWROP/PIRDOP/PIRWOP and the clog2 function.
REQ-037 Sub-module pi1_sram_ram SHALL contain the inferred single-port, byte-enable, read-first array with SRCFILE init.
REQ-038 FSM, counter and handshake SHALL live in pi1_sram.

Verification
REQ-039 DELAY=0, write 0xDEADBEEF to addr 5 with sel=1111, then read 5 -> data_o=0xDEADBEEF the cycle after read acceptance, rdy_o never 0.
REQ-040 DELAY=3, read addr 5 -> rdy_o low for exactly 3 cycles, then high with 0xDEADBEEF.
REQ-041 Write 0x11223344 with sel=0101 over 0xDEADBEEF, then read -> 0xDE22BE44.
REQ-042 SIZE=1024, write 0xA5A5A5A5 to addr 1024+7, then read addr 7 -> 0xA5A5A5A5.
REQ-043 RWOP_EN, swap 0xCAFEF00D into addr 9 holding 0x0 -> returns 0x0; next read returns 0xCAFEF00D. Without the macro -> returns 0x0, memory unchanged.
REQ-044 DELAY=5, rst_i=0 two cycles into a write to addr 2 -> rdy_o=1 and data_o=0 the next cycle; a later read of addr 2 returns the written data.
